mem_bus_ram: RTL and testbench

- Line-granular on-chip RAM responder on the external 128-bit memory bus of the execute-unit top, i.e. directly downstream of the L1 memory block.
- Accepts one line load or line store at a time over a four-phase Opm/OK handshake.
- Inserts a programmable wait latency so the core's hold/stall paths are exercised.
- Serves as the simulation and FPGA backing store until the DRAM controller exists.

---
 rtl/mem_bus_ram.sv | 68 ++++++
 tb/tb_mem_bus_ram.sv | 118 +++++++++++
 2 files changed

// File: rtl/mem_bus_ram.sv
// mem_bus_ram: line-granular 128-bit RAM responder with Opm/OK handshake and programmable wait latency.
// Optional address/ROM-write faulting is enabled by defining MEM_BUS_FAULT_EN.
module mem_bus_ram #(
  parameter int ADDR_BITS = 14,
  parameter int LATENCY   = 4,
  parameter int ROM_LINES = 256
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  busAddr,
  input  logic [4:0]   busOpm,
  input  logic [127:0] busDataIn,
  output logic [127:0] busDataOut,
  output logic [1:0]   busOK
);
  localparam int LB = ADDR_BITS - 4;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t         state;
  logic [LB-1:0]  idx;
  logic           st;
  logic           flt;
  logic [127:0]   wdata;
  logic [7:0]     cnt;
  logic [127:0]   mem [0:(1<<LB)-1];
  logic           is_ld, is_st, req_flt, unused_bits;
  assign is_ld = busOpm[4:3] == 2'b01;
  assign is_st = busOpm[4:3] == 2'b10;
  assign unused_bits = ^{busAddr[31:ADDR_BITS], busAddr[3:0], busOpm[2:0]};
`ifdef MEM_BUS_FAULT_EN
  assign req_flt = (busAddr[31:ADDR_BITS] != '0) || (is_st && int'(busAddr[ADDR_BITS-1:4]) < ROM_LINES);
`else
  assign req_flt = 1'b0;
`endif
  // Kept apart from the FSM so the array maps onto a single-port block RAM.
  always_ff @(posedge clock)
    if (!reset && state == WAIT && cnt == '0 && st && !flt) mem[idx] <= wdata;
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      busOK      <= 2'b00;
      busDataOut <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (is_ld || is_st) begin
          idx   <= busAddr[ADDR_BITS-1:4];
          st    <= is_st;
          flt   <= req_flt;
          wdata <= busDataIn;
          cnt   <= 8'(LATENCY);
          state <= WAIT;
          busOK <= 2'b10;
        end
        WAIT: if (cnt == '0) begin
          state <= DONE;
          busOK <= flt ? 2'b11 : 2'b01;
          if (flt) busDataOut <= '0;
          else if (!st) busDataOut <= mem[idx];
        end else cnt <= cnt - 8'd1;
        DONE: if (busOpm == 5'h00) begin
          state <= IDLE;
          busOK <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_ram.sv
// tb_mem_bus_ram: scoreboard bench for mem_bus_ram at LATENCY=4 (u0) and LATENCY=0 (u1).
module tb_mem_bus_ram;
  localparam logic [4:0] LD = 5'b01000, ST = 5'b10000;
  typedef struct packed {logic [1:0] ok; logic [127:0] d;} rsp_t;
  logic clock = 0, reset = 1;
  logic [31:0]  addr [2];
  logic [4:0]   opm  [2];
  logic [127:0] din  [2];
  logic [127:0] dout [2];
  logic [1:0]   ok   [2];
  logic [127:0] model [int];
  logic [127:0] exp_out [2];
  rsp_t sb [$];
  int tests = 0, fails = 0, cyc = 0, last_acc = 0, a1;
  mem_bus_ram #(.LATENCY(4)) u0 (.clock(clock), .reset(reset), .busAddr(addr[0]), .busOpm(opm[0]),
    .busDataIn(din[0]), .busDataOut(dout[0]), .busOK(ok[0]));
  mem_bus_ram #(.LATENCY(0)) u1 (.clock(clock), .reset(reset), .busAddr(addr[1]), .busOpm(opm[1]),
    .busDataIn(din[1]), .busDataOut(dout[1]), .busOK(ok[1]));
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic is_fault(input logic [31:0] a, input logic s);
`ifdef MEM_BUS_FAULT_EN
    return (a[31:14] != 0) || (s && a[13:4] < 10'd256);
`else
    return 1'b0;
`endif
  endfunction
  // One request; alt swaps address/data right after accept to prove they are ignored.
  task automatic xfer(input int u, input logic [31:0] a, input logic [4:0] op, input logic [127:0] d,
                      input int extra, input logic alt);
    logic s, f;
    int key, n;
    logic [127:0] prev;
    rsp_t e;
    s = op[4:3] == 2'b10;
    f = is_fault(a, s);
    key = u * 1024 + int'(a[13:4]);
    prev = exp_out[u];
    if (f) exp_out[u] = '0;
    else if (s) model[key] = d;
    else exp_out[u] = model.exists(key) ? model[key] : 'x;
    sb.push_back({f ? 2'b11 : 2'b01, exp_out[u]});
    addr[u] = a; opm[u] = op; din[u] = d;
    @(negedge clock);
    last_acc = cyc;
    if (alt) begin addr[u] = a + 32'h10; din[u] = ~d; end
    n = 0;
    while (ok[u] == 2'b10 && n < 300) begin
      check("hold_data", dout[u], prev);
      n++;
      @(negedge clock);
    end
    check("hold_cycles", n, (u == 0) ? 5 : 1);
    e = sb.pop_front();
    check("ok", ok[u], e.ok);
    check("data", dout[u], e.d);
    repeat (extra) begin
      @(negedge clock);
      check("done_ok", ok[u], e.ok);
      check("done_data", dout[u], e.d);
    end
    opm[u] = 5'h00;
    @(negedge clock);
    check("idle_ok", ok[u], 2'b00);
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; opm[i] = '0; din[i] = '0; exp_out[i] = '0;
    end
    repeat (3) @(negedge clock);
    check("rst_ok0", ok[0], 2'b00);
    check("rst_data0", dout[0], '0);
    check("rst_ok1", ok[1], 2'b00);
    reset = 0;
    xfer(0, 32'h3000, ST, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, 0);
    xfer(0, 32'h3008, LD, '0, 0, 0);
    xfer(0, 32'h3010, ST, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 0, 0);
    xfer(0, 32'h3000, ST, 128'hA5A5_0000_FFFF_1234_DEAD_BEEF_CAFE_F00D, 0, 1);
    xfer(0, 32'h3010, LD, '0, 0, 0);
    a1 = last_acc;
    xfer(0, 32'h3000, LD, '0, 0, 0);
    check("b2b_spacing", last_acc - a1, 7);
    opm[0] = 5'b11000;
    repeat (3) begin @(negedge clock); check("none_op", ok[0], 2'b00); end
    opm[0] = 5'h00;
    @(negedge clock);
    addr[0] = 32'h3000; opm[0] = ST; din[0] = 128'h5;
    repeat (2) @(negedge clock);
    reset = 1; opm[0] = 5'h00;
    @(negedge clock);
    reset = 0;
    check("abort_ok", ok[0], 2'b00);
    check("abort_data", dout[0], '0);
    exp_out[0] = '0; exp_out[1] = '0;
    xfer(0, 32'h3000, 5'b01111, '0, 0, 0);
`ifdef MEM_BUS_FAULT_EN
    xfer(0, 32'h0100, ST, 128'h7777, 0, 0);
    xfer(0, 32'h0001_0000, LD, '0, 0, 0);
    xfer(0, 32'h2000, ST, 128'h8888_9999, 0, 0);
    xfer(0, 32'h2000, LD, '0, 0, 0);
`else
    xfer(0, 32'h0001_3000, LD, '0, 0, 0);
    xfer(0, 32'h0100, ST, 128'h7777, 0, 0);
    xfer(0, 32'h0100, LD, '0, 0, 0);
`endif
    xfer(1, 32'h2040, ST, 128'hCAFE_BABE_0000_0001, 0, 0);
    xfer(1, 32'h2040, LD, '0, 3, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
